// File: rtl/servo_pkg.sv
// Shared types and defaults for the servo command path.
package servo_pkg;

  localparam int unsigned DUTY_W        = 8;
  localparam int unsigned DUTY_MIN_DEF  = 0;
  localparam int unsigned DUTY_MAX_DEF  = 128;
  localparam int unsigned DUTY_INIT_DEF = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    LATCH = 1'b1
  } state_t;

  // Limit a requested position to the legal duty window.
  function automatic logic [DUTY_W-1:0] clamp_duty(
    input logic [DUTY_W-1:0] v,
    input logic [DUTY_W-1:0] lo,
    input logic [DUTY_W-1:0] hi
  );
    if (v >= hi) begin
      return hi;
    end else if (v <= lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running servo frame counter with a registered end-of-frame pulse.
module servo_frame_timer #(
  parameter int unsigned FRAME_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  output logic frame_tick
);

  localparam int unsigned     CNT_W    = $clog2(FRAME_CYCLES);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(FRAME_CYCLES - 2);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  // Counter wraps at LAST; tick is registered so it coincides with count == LAST.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      r_tick <= (r_cnt == PRE_LAST);
    end
  end

  assign frame_tick = r_tick;

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Rate-limited duty command for the servo PWM generator: one bounded step per frame,
// each new duty handed over with a fixed-length latch strobe.
module servo_ramp_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = 1000000,
  parameter int unsigned LATCH_CYCLES = 1024,
  parameter int unsigned STEP         = 1,
  parameter int unsigned DUTY_MIN     = DUTY_MIN_DEF,
  parameter int unsigned DUTY_MAX     = DUTY_MAX_DEF,
  parameter int unsigned DUTY_INIT    = DUTY_INIT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DUTY_W-1:0] target,
  input  logic              target_valid,
  output logic [DUTY_W-1:0] duty,
  output logic              latch,
  output logic              at_target,
  output logic              frame_tick
);

  localparam int unsigned       DIFF_W = DUTY_W + 1;
  localparam int unsigned       LCNT_W = $clog2(LATCH_CYCLES) + 1;
  localparam logic [DUTY_W-1:0] D_MIN  = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] D_MAX  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] D_INIT = DUTY_W'(DUTY_INIT);
  localparam logic [DIFF_W-1:0] STEP_V = DIFF_W'(STEP);
  localparam logic [LCNT_W-1:0] L_LAST = LCNT_W'(LATCH_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DUTY_W-1:0] r_duty;
  logic [DUTY_W-1:0] w_duty_nxt;
  logic [DUTY_W-1:0] r_tgt;
  logic [DUTY_W-1:0] w_tgt_nxt;
  logic              r_sync;
  logic              w_sync_nxt;
  logic [LCNT_W-1:0] r_lcnt;
  logic [LCNT_W-1:0] w_lcnt_nxt;
  logic              r_latch;
  logic              w_latch_nxt;
  logic              r_at_target;
  logic              w_at_target_nxt;
  logic              w_tick;
  logic [DIFF_W-1:0] w_up_diff;
  logic [DIFF_W-1:0] w_dn_diff;
  logic [DIFF_W-1:0] w_up_step;
  logic [DIFF_W-1:0] w_dn_step;

  servo_frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_frame_timer (
    .clock      (clock),
    .reset      (reset),
    .frame_tick (w_tick)
  );

  // Distance to target in 9 bits; the step is capped by it so duty never overshoots.
  assign w_up_diff = {1'b0, r_tgt} - {1'b0, r_duty};
  assign w_dn_diff = {1'b0, r_duty} - {1'b0, r_tgt};
  assign w_up_step = (w_up_diff < STEP_V) ? w_up_diff : STEP_V;
  assign w_dn_step = (w_dn_diff < STEP_V) ? w_dn_diff : STEP_V;

  // State, duty, target and latch-counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_duty      <= D_INIT;
      r_tgt       <= D_INIT;
      r_sync      <= 1'b1;
      r_lcnt      <= '0;
      r_latch     <= 1'b0;
      r_at_target <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_duty      <= w_duty_nxt;
      r_tgt       <= w_tgt_nxt;
      r_sync      <= w_sync_nxt;
      r_lcnt      <= w_lcnt_nxt;
      r_latch     <= w_latch_nxt;
      r_at_target <= w_at_target_nxt;
    end
  end

  // Next-state, step and registered-output logic; outputs follow the next state so
  // latch rises together with the new duty.
  always_comb begin
    w_state_nxt     = r_state;
    w_duty_nxt      = r_duty;
    w_tgt_nxt       = r_tgt;
    w_sync_nxt      = r_sync;
    w_lcnt_nxt      = '0;
    w_latch_nxt     = 1'b0;
    w_at_target_nxt = 1'b0;

    if (target_valid) begin
      w_tgt_nxt = clamp_duty(target, D_MIN, D_MAX);
    end

    case (r_state)
      IDLE: begin
        if (w_tick && ((r_duty != r_tgt) || r_sync)) begin
          w_state_nxt = LATCH;
          w_sync_nxt  = 1'b0;
          if (r_duty < r_tgt) begin
            w_duty_nxt = r_duty + DUTY_W'(w_up_step);
          end else if (r_duty > r_tgt) begin
            w_duty_nxt = r_duty - DUTY_W'(w_dn_step);
          end
        end
      end
      LATCH: begin
        if (r_lcnt == L_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_lcnt_nxt = r_lcnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_latch_nxt     = (w_state_nxt == LATCH);
    w_at_target_nxt = (w_duty_nxt == w_tgt_nxt) && (w_state_nxt == IDLE) && !w_sync_nxt;
  end

`ifndef SYNTHESIS
  // A frame boundary must never land inside a latch window.
  always @(posedge clock) begin
    if (!reset) begin
      assert (!(w_tick && (r_state == LATCH)));
    end
  end
`endif

  assign duty       = r_duty;
  assign latch      = r_latch;
  assign at_target  = r_at_target;
  assign frame_tick = w_tick;

endmodule
